// File: rtl/anim_trigger_ctrl.sv
// Sprite animation launch controller: queues hit positions and hands them to the
// animation sequencer one at a time using an enable-pulse / active-flag handshake.
module anim_trigger_ctrl #(
   parameter int DEPTH       = 4,
   parameter int POS_W       = 10,
   parameter int MIN_GAP     = 2,
   parameter int ACK_TIMEOUT = 4
) (
   input  logic                       Clk,
   input  logic                       Reset_n,
   input  logic                       hitValid,
   input  logic [POS_W-1:0]           hitX,
   input  logic [POS_W-1:0]           hitY,
   input  logic                       AnimationActive,
   input  logic                       clearErr,
   output logic                       animationEnable,
   output logic [POS_W-1:0]           animX,
   output logic [POS_W-1:0]           animY,
   output logic                       busy,
   output logic [$clog2(DEPTH+1)-1:0] pending,
   output logic                       overflow,
   output logic                       timeoutErr
);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int TMO_W = $clog2(ACK_TIMEOUT+1);
   localparam int GAP_W = (MIN_GAP < 1) ? 1 : $clog2(MIN_GAP+1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_GAP
   } state_t;

   state_t           state;
   logic [POS_W-1:0] mem_x [DEPTH];
   logic [POS_W-1:0] mem_y [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [TMO_W-1:0] tmo_cnt;
   logic [GAP_W-1:0] gap_cnt;
   logic             pop;
   logic             push;
   logic             drop;
   logic             ack_expire;

   // Pop looks at the registered occupancy, so a hit pushed on this edge launches no earlier than the next.
   assign pop        = (state == S_IDLE) && (pending != '0) && (gap_cnt == '0);
   assign push       = hitValid && ((pending != CNT_W'(DEPTH)) || pop);
   assign drop       = hitValid && (pending == CNT_W'(DEPTH)) && !pop;
   assign ack_expire = (state == S_WAIT_ACK) && !AnimationActive && (tmo_cnt == TMO_W'(1));
   assign busy       = (state != S_IDLE);

   // NOTE: the storage array has no reset; pointers and occupancy alone decide which entries are valid.
   always_ff @(posedge Clk) begin
      if (push) begin
         mem_x[wr_ptr] <= hitX;
         mem_y[wr_ptr] <= hitY;
      end
   end

   // NOTE: non-blocking assignments throughout, so every flop samples pre-edge values regardless of block order.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   pending <= pending + CNT_W'(1);
            2'b01:   pending <= pending - CNT_W'(1);
            default: pending <= pending;
         endcase
         if (drop)          overflow <= 1'b1;
         else if (clearErr) overflow <= 1'b0;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state           <= S_IDLE;
         animationEnable <= 1'b0;
         animX           <= '0;
         animY           <= '0;
         tmo_cnt         <= '0;
         gap_cnt         <= '0;
         timeoutErr      <= 1'b0;
      end else begin
         animationEnable <= 1'b0;
         if (ack_expire)    timeoutErr <= 1'b1;
         else if (clearErr) timeoutErr <= 1'b0;

         case (state)
            S_IDLE: begin
               if (pop) begin
                  animX           <= mem_x[rd_ptr];
                  animY           <= mem_y[rd_ptr];
                  animationEnable <= 1'b1;
                  state           <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               tmo_cnt <= TMO_W'(ACK_TIMEOUT);
               state   <= S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
               // An unacknowledged launch is abandoned; the event is not retried.
               if (AnimationActive) begin
                  state <= S_WAIT_DONE;
               end else if (ack_expire) begin
                  gap_cnt <= GAP_W'(MIN_GAP);
                  state   <= S_GAP;
               end else begin
                  tmo_cnt <= tmo_cnt - TMO_W'(1);
               end
            end
            S_WAIT_DONE: begin
               if (!AnimationActive) begin
                  gap_cnt <= GAP_W'(MIN_GAP);
                  state   <= S_GAP;
               end
            end
            S_GAP: begin
               if (gap_cnt <= GAP_W'(1)) begin
                  gap_cnt <= '0;
                  state   <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GAP_W'(1);
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
